div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle sequencer for the DIV/DIVU instructions in the execute stage of the 5-stage MIPS pipeline.
- Accepts operands when the decoded control flags a divide, and runs a 32-step restoring division.
- Holds the pipeline through a stall request, then writes quotient/remainder to the HI/LO register with a one-cycle write strobe.
- Sits beside the ALU and feeds the hazard unit's stall logic.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- div_startE  in  1  execute-stage instruction is DIV/DIVU; level, held while stalled.
- div_signedE  in  1  1=DIV (signed), 0=DIVU.
- srcaE  in  WIDTH  dividend (rs).
- srcbE  in  WIDTH  divisor (rt).
- flushE  in  1  annul the execute-stage instruction.
- div_stallE  out  1  stall request to the hazard unit (freeze F/D/E).
- div_readyE  out  1  one-cycle result-valid pulse.
- hilowrite_divE  out  1  HI/LO write enable; equals div_readyE & ~flushE.
- hi_divE  out  WIDTH  remainder.
- lo_divE  out  WIDTH  quotient.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, counter=0; all outputs and internal registers are 0.
- IDLE
  - If div_startE & ~flushE: latch |srcaE| and |srcbE| (abs only when div_signedE), the quotient sign (signs differ) and the remainder sign (dividend sign).
  - Zero divisor: go to DONE.
  - Otherwise: go to BUSY with counter=0.
- BUSY
  - One restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor, set the quotient LSB.
  - Counter increments each step; after counter==31 (32 steps) go to DONE.
- DONE
  - div_readyE=1 for exactly this cycle.
  - hi/lo are sign-corrected: quotient negated if signs differ, remainder takes the dividend sign.
  - Always return to IDLE next cycle.
- Stall timing: div_stallE = (IDLE & div_startE & ~flushE) | BUSY, combinational.
  - Normal divide accepted in cycle t: stall high t..t+32, ready at t+33, stall low at t+33 so the instruction advances.
- Divide by zero: DONE at t+1; lo = all ones, hi = raw dividend; no sign correction. Stall high in cycle t only.
- Signed overflow 0x80000000 / 0xFFFFFFFF: the natural two's-complement wrap gives lo=0x80000000, hi=0.
- flushE in BUSY: return to IDLE next cycle; no ready, no write; stall drops in the cycle after flushE.
- flushE in DONE: ready still pulses, hilowrite_divE=0.
- div_startE in BUSY/DONE is ignored; a new divide is accepted only from IDLE.
- A divide still asserted in the cycle after DONE (a genuine back-to-back DIV) starts a new operation.
- Reset low in any state: IDLE on that edge; outputs 0 the next cycle; in-flight result is discarded.
- hi_divE/lo_divE hold their last DONE values until the next DONE.

Decomposition:
- Shared defines header:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - DIV/DIVU alucontrol codes, shared with aludec
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside the BUSY datapath.

Test Plan:
- DIVU 100/7, start at cycle t → stall high for 33 cycles; ready and hilowrite at t+33; lo=0x0000000E, hi=0x00000002.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); same latency.
- DIVU 5/0 → ready at t+1, stall in cycle t only; lo=0xFFFFFFFF, hi=0x00000005.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- Start 100/7, assert flushE in BUSY cycle 10 → no ready/hilowrite, stall low next cycle; then DIVU 9/3 → lo=3, hi=0 at start+33.
- Start a divide, drive rst=0 in BUSY cycle 5 → IDLE; all outputs 0 the cycle after the reset edge; no write strobe.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the execute-stage divide sequencer: FSM encodings and
// the ALU control codes that aludec uses to flag DIV/DIVU.
package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [3:0] ALU_DIV  = 4'b1010;
  localparam logic [3:0] ALU_DIVU = 4'b1011;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor and record the quotient bit.
module div_sequencer_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // One extra bit keeps the trial subtract exact when the divisor has its MSB set.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, divisor_i};

  assign rem_o = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU sequencer beside the ALU: stalls the pipeline through a 32-step
// restoring division and pulses a HI/LO write when the result is ready.
//
// state | meaning
// IDLE  | waiting for a divide in execute
// BUSY  | one restoring step per cycle, stall held
// DONE  | result valid for one cycle, write strobe unless flushed
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_startE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  output logic             div_stallE,
  output logic             div_readyE,
  output logic             hilowrite_divE,
  output logic [WIDTH-1:0] hi_divE,
  output logic [WIDTH-1:0] lo_divE
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             neg_quo_q, neg_rem_q, ready_q;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             last_step;

  assign accept    = (state_q == IDLE) & div_startE & ~flushE;
  assign a_neg     = div_signedE & srcaE[WIDTH-1];
  assign b_neg     = div_signedE & srcbE[WIDTH-1];
  assign a_abs     = a_neg ? -srcaE : srcaE;
  assign b_abs     = b_neg ? -srcbE : srcbE;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  div_sequencer_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dvs_q     <= b_abs;
            rem_q     <= '0;
            quo_q     <= a_abs;
            cnt_q     <= '0;
            // Zero divisor skips the iterations and reports the raw dividend.
            if (srcbE == '0) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              lo_q    <= '1;
              hi_q    <= srcaE;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flushE) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              lo_q    <= neg_quo_q ? -quo_d : quo_d;
              hi_q    <= neg_rem_q ? -rem_d : rem_d;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_stallE     = accept | (state_q == BUSY);
  assign div_readyE     = ready_q;
  assign hilowrite_divE = ready_q & ~flushE;
  assign hi_divE        = hi_q;
  assign lo_divE        = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, sign handling, divide by zero,
// overflow, flush in BUSY/DONE, back-to-back and mid-operation reset.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_startE, div_signedE, flushE;
  logic [31:0] srcaE, srcbE;
  logic        div_stallE, div_readyE, hilowrite_divE;
  logic [31:0] hi_divE, lo_divE;

  int checks   = 0;
  int failures = 0;

  div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_startE     (div_startE),
    .div_signedE    (div_signedE),
    .srcaE          (srcaE),
    .srcbE          (srcbE),
    .flushE         (flushE),
    .div_stallE     (div_stallE),
    .div_readyE     (div_readyE),
    .hilowrite_divE (hilowrite_divE),
    .hi_divE        (hi_divE),
    .lo_divE        (lo_divE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Start a divide in the current cycle, expect ready exactly lat cycles later.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int lat);
    div_startE  = 1'b1;
    div_signedE = sgn;
    srcaE       = a;
    srcbE       = b;
    #1;
    chk({tag, "_stall_t0"}, {31'd0, div_stallE}, 32'd1);
    for (int i = 1; i < lat; i++) begin
      tick();
      chk({tag, "_stall_busy"}, {31'd0, div_stallE}, 32'd1);
      chk({tag, "_ready_early"}, {31'd0, div_readyE}, 32'd0);
    end
    tick();
    chk({tag, "_ready"}, {31'd0, div_readyE}, 32'd1);
    chk({tag, "_hilowrite"}, {31'd0, hilowrite_divE}, 32'd1);
    chk({tag, "_stall_done"}, {31'd0, div_stallE}, 32'd0);
    chk({tag, "_lo"}, lo_divE, exp_lo);
    chk({tag, "_hi"}, hi_divE, exp_hi);
    div_startE = 1'b0;
    tick();
    chk({tag, "_ready_after"}, {31'd0, div_readyE}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; div_startE = 1'b0; div_signedE = 1'b0; flushE = 1'b0;
    srcaE = '0; srcbE = '0;
    tick(); tick();
    chk("rst_stall", {31'd0, div_stallE}, 32'd0);
    chk("rst_ready", {31'd0, div_readyE}, 32'd0);
    chk("rst_hilowrite", {31'd0, hilowrite_divE}, 32'd0);
    chk("rst_hi", hi_divE, 32'd0);
    chk("rst_lo", lo_divE, 32'd0);
    rst = 1'b1;
    tick();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 33);
    tick();
    chk("hold_lo", lo_divE, 32'h0000000E);
    chk("hold_hi", hi_divE, 32'h00000002);

    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33);
    run_div("divu_big", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'h00000001, 33);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h00000005, 1);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33);

    // Back-to-back: divide still asserted after DONE starts a new operation.
    div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd8; srcbE = 32'd0;
    tick();
    chk("b2b_ready1", {31'd0, div_readyE}, 32'd1);
    srcaE = 32'd9;
    tick();
    chk("b2b_stall2", {31'd0, div_stallE}, 32'd1);
    tick();
    chk("b2b_ready2", {31'd0, div_readyE}, 32'd1);
    chk("b2b_hi2", hi_divE, 32'd9);
    div_startE = 1'b0;
    tick();

    // Flush in DONE: ready pulses, no write.
    div_startE = 1'b1; srcaE = 32'd3; srcbE = 32'd0;
    tick();
    flushE = 1'b1;
    #1;
    chk("flushdone_ready", {31'd0, div_readyE}, 32'd1);
    chk("flushdone_write", {31'd0, hilowrite_divE}, 32'd0);
    div_startE = 1'b0; flushE = 1'b0;
    tick();

    // Flush in BUSY cycle 10.
    div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd100; srcbE = 32'd7;
    repeat (10) tick();
    flushE = 1'b1;
    #1;
    chk("flushbusy_stall", {31'd0, div_stallE}, 32'd1);
    chk("flushbusy_write", {31'd0, hilowrite_divE}, 32'd0);
    tick();
    flushE = 1'b0; div_startE = 1'b0;
    #1;
    chk("flush_stall_drop", {31'd0, div_stallE}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("flush_no_ready", {31'd0, div_readyE}, 32'd0);
    end
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // Reset in BUSY cycle 5 discards the operation.
    div_startE = 1'b1; srcaE = 32'd100; srcbE = 32'd7;
    repeat (5) tick();
    rst = 1'b0; div_startE = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rstbusy_stall", {31'd0, div_stallE}, 32'd0);
    chk("rstbusy_ready", {31'd0, div_readyE}, 32'd0);
    chk("rstbusy_write", {31'd0, hilowrite_divE}, 32'd0);
    chk("rstbusy_hi", hi_divE, 32'd0);
    chk("rstbusy_lo", lo_divE, 32'd0);
    for (int i = 0; i < 35; i++) begin
      tick();
      chk("rstbusy_no_write", {31'd0, hilowrite_divE}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
